// File: rtl/native_mem_slave.sv
// PicoRV32 native-interface responder: on-chip RAM, GPIO/timer/status registers and
// a sticky bus-error flag, answering each request after WAIT_STATES extra cycles.
module native_mem_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] IO_BASE     = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [31:0] gpio_out,
  output logic        bus_err
);
  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;
  typedef enum logic [1:0] {RG_RAM, RG_IO, RG_NONE} region_t;

  state_t      state_q, state_d;
  region_t     region_q, region_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic        ram_we;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] cur_addr;
  logic [3:0]  cur_wstrb;
  region_t     cur_region;
  logic        unused_instr;

  assign unused_instr = mem_instr;

  // Unsigned wrap makes addresses below the base fall outside the window too.
  function automatic region_t decode(input logic [31:0] a);
    if ((a - RAM_BASE) < RAM_BYTES) return RG_RAM;
    if ((a - IO_BASE) < 32'd16) return RG_IO;
    return RG_NONE;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ready_d   = 1'b0;
    rdata_d   = '0;
    gpio_d    = gpio_q;
    timer_d   = timer_q + 32'd1;
    err_d     = err_q;
    ram_we    = 1'b0;

    // With zero wait states the response is prepared on the capture edge itself.
    cur_addr   = (state_q == S_IDLE) ? mem_addr : addr_q;
    cur_wstrb  = (state_q == S_IDLE) ? mem_wstrb : wstrb_q;
    cur_region = (state_q == S_IDLE) ? decode(mem_addr) : region_q;

    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          wstrb_d  = mem_wstrb;
          region_d = decode(mem_addr);
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!mem_valid)          state_d = S_IDLE;
        else if (cnt_q == 4'd0)  state_d = S_RESP;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d = S_DONE;
        if (wstrb_q != 4'b0000) begin
          case (region_q)
            RG_RAM: ram_we = 1'b1;
            RG_IO: begin
              case (addr_q[3:2])
                2'd0:    gpio_d  = merge_bytes(gpio_q, wdata_q, wstrb_q);
                2'd1:    timer_d = '0;
                2'd2:    if (wdata_q[0]) err_d = 1'b0;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        if (region_q == RG_NONE) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RESP) begin
      ready_d = 1'b1;
      if (cur_wstrb == 4'b0000) begin
        case (cur_region)
          RG_RAM: rdata_d = mem[cur_addr[AW+1:2]];
          RG_IO: begin
            case (cur_addr[3:2])
              2'd0:    rdata_d = gpio_q;
              2'd1:    rdata_d = timer_q;
              2'd2:    rdata_d = {31'b0, err_q};
              default: rdata_d = '0;
            endcase
          end
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      region_q <= RG_NONE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      gpio_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      gpio_q   <= gpio_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  // RAM contents survive reset; reads happen before this write in the same transaction.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign gpio_out  = gpio_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_native_mem_slave.sv
// Bench for native_mem_slave: two instances (1 and 3 wait states) driven by directed and
// random transactions, checked against a word/register-level model of the memory map.
module tb_native_mem_slave;
  localparam int          MEMW    = 64;
  localparam logic [31:0] RAMBASE = 32'h0000_0000;
  localparam logic [31:0] IOBASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn [2];
  logic        valid  [2];
  logic        instr  [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        ready  [2];
  logic [31:0] rdata  [2];
  logic [31:0] gpio   [2];
  logic        err    [2];

  int cyc = 0;
  int passCount = 0;
  int failCount = 0;
  int totalCount = 0;

  // Reference state: memory words, GPIO register and error flag per instance.
  logic [31:0] ramModel [2][MEMW];
  logic [31:0] gpioModel [2];
  logic        errModel [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  native_mem_slave #(.MEM_WORDS(MEMW), .WAIT_STATES(1), .RAM_BASE(RAMBASE), .IO_BASE(IOBASE)) dut0 (
    .clk(clk), .resetn(resetn[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_ready(ready[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_rdata(rdata[0]), .gpio_out(gpio[0]), .bus_err(err[0]));

  native_mem_slave #(.MEM_WORDS(MEMW), .WAIT_STATES(3), .RAM_BASE(RAMBASE), .IO_BASE(IOBASE)) dut1 (
    .clk(clk), .resetn(resetn[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_ready(ready[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_rdata(rdata[1]), .gpio_out(gpio[1]), .bus_err(err[1]));

  function automatic int waitStatesOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] strbMask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Applies one transaction to the model; returns the expected read data and whether it is predictable here.
  function automatic void modelCommit(input int d, input logic [31:0] a, input logic [31:0] wd,
                                      input logic [3:0] strb, output logic [31:0] expRd, output bit known);
    logic [31:0] mask;
    int idx;
    mask  = strbMask(strb);
    expRd = 32'h0;
    known = (strb == 4'b0000);
    if (a >= RAMBASE && a < RAMBASE + 4 * MEMW) begin
      idx = int'((a - RAMBASE) / 4);
      if (strb == 4'b0000) expRd = ramModel[d][idx];
      else ramModel[d][idx] = (ramModel[d][idx] & ~mask) | (wd & mask);
    end else if (a >= IOBASE && a < IOBASE + 16) begin
      case ((a - IOBASE) / 4)
        0: begin
          if (strb == 4'b0000) expRd = gpioModel[d];
          else gpioModel[d] = (gpioModel[d] & ~mask) | (wd & mask);
        end
        1: known = 1'b0;
        2: begin
          if (strb == 4'b0000) expRd = {31'b0, errModel[d]};
          else if (wd[0]) errModel[d] = 1'b0;
        end
        default: expRd = 32'h0;
      endcase
    end else begin
      errModel[d] = 1'b1;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete request: drive from IDLE, wait for mem_ready, check DONE cycle, return in IDLE.
  task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] strb, output logic [31:0] rd, output int readyCyc);
    logic [31:0] expRd;
    bit known;
    bit seen;
    int waited;
    modelCommit(d, a, wd, strb, expRd, known);
    @(negedge clk);
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = strb;
    instr[d] = 1'($urandom);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
      if (ready[d]) seen = 1'b1;
    end
    rd = rdata[d];
    readyCyc = cyc;
    checkOutput("latency", 32'(waited), 32'(waitStatesOf(d) + 1));
    if (known) checkOutput("rdata", rd, expRd);
    valid[d] = 1'b0;
    wstrb[d] = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("done_ready", {31'b0, ready[d]}, 32'h0);
    checkOutput("done_rdata", rdata[d], 32'h0);
    checkOutput("gpio", gpio[d], gpioModel[d]);
    checkOutput("bus_err", {31'b0, err[d]}, {31'b0, errModel[d]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd, t1, t2, t3, a;
    logic [3:0]  s;
    int c1, c2, cw, cr, kind, hits;

    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0;
      valid[d] = 1'b0;
      instr[d] = 1'b0;
      addr[d] = '0;
      wdata[d] = '0;
      wstrb[d] = '0;
      gpioModel[d] = '0;
      errModel[d] = 1'b0;
    end
    #12;
    checkOutput("reset_ready", {31'b0, ready[0]}, 32'h0);
    checkOutput("reset_rdata", rdata[0], 32'h0);
    checkOutput("reset_gpio", gpio[0], 32'h0);
    checkOutput("reset_err", {31'b0, err[0]}, 32'h0);
    @(negedge clk);
    resetn[0] = 1'b1;
    resetn[1] = 1'b1;

    // Directed RAM traffic: full word, then byte-strobe merge.
    applyStimulus(0, 32'h10, 32'hA5A5_1234, 4'hF, rd, c1);
    applyStimulus(0, 32'h10, 32'h0, 4'h0, rd, c1);
    checkOutput("tp_ram_read", rd, 32'hA5A5_1234);
    applyStimulus(0, 32'h20, 32'hFFFF_FFFF, 4'hF, rd, c1);
    applyStimulus(0, 32'h20, 32'h0000_00AB, 4'b0001, rd, c1);
    applyStimulus(0, 32'h20, 32'h0, 4'h0, rd, c1);
    checkOutput("tp_strobe", rd, 32'hFFFF_FFAB);

    // GPIO upper-half write and readback.
    applyStimulus(0, IOBASE, 32'h1234_5678, 4'b1100, rd, c1);
    applyStimulus(0, IOBASE, 32'h0, 4'h0, rd, c1);
    checkOutput("tp_gpio", rd, 32'h1234_0000);

    // Fill the rest of RAM with random words, then random mixed traffic against the model.
    for (int i = 0; i < MEMW; i++) begin
      if (i != 4 && i != 8) applyStimulus(0, RAMBASE + 32'(4 * i), $urandom, 4'hF, rd, c1);
    end
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (kind <= 5)      a = RAMBASE + 32'($urandom_range(0, MEMW - 1) * 4) + 32'($urandom_range(0, 3));
      else if (kind == 6) a = IOBASE;
      else if (kind == 7) a = IOBASE + 32'h8;
      else if (kind == 8) a = IOBASE + 32'hC;
      else                a = 32'h2000_0000 + 32'($urandom_range(0, 255) * 4);
      applyStimulus(0, a, $urandom, s, rd, c1);
    end

    // Window edges: last RAM word, first address past RAM, reserved I/O slot, past I/O window.
    applyStimulus(0, 32'h0000_0000 + 32'(4 * MEMW - 4), 32'h0, 4'h0, rd, c1);
    applyStimulus(0, IOBASE + 32'h8, 32'h1, 4'h1, rd, c1);
    applyStimulus(0, IOBASE + 32'hC, 32'hFFFF_FFFF, 4'hF, rd, c1);
    applyStimulus(0, IOBASE + 32'hC, 32'h0, 4'h0, rd, c1);
    applyStimulus(0, 32'(4 * MEMW), 32'h0, 4'h0, rd, c1);
    applyStimulus(0, IOBASE + 32'h10, 32'h0, 4'h0, rd, c1);

    // Unmapped read sets the sticky flag; STATUS write of 1 clears it.
    applyStimulus(0, IOBASE + 32'h8, 32'h1, 4'hF, rd, c1);
    applyStimulus(0, 32'h2000_0000, 32'h0, 4'h0, rd, c1);
    checkOutput("tp_unmapped_rdata", rd, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("tp_err_sticky", {31'b0, err[0]}, 32'h1);
    applyStimulus(0, IOBASE + 32'h8, 32'h1, 4'hF, rd, c1);
    checkOutput("tp_err_cleared", {31'b0, err[0]}, 32'h0);

    // Timer: elapsed cycles between identical reads, then clear with a partial strobe.
    applyStimulus(0, IOBASE + 32'h4, 32'h0, 4'h0, t1, c1);
    repeat (10) @(posedge clk);
    applyStimulus(0, IOBASE + 32'h4, 32'h0, 4'h0, t2, c2);
    checkOutput("timer_delta", t2 - t1, 32'(c2 - c1));
    applyStimulus(0, IOBASE + 32'h4, 32'hFFFF_FFFF, 4'b0010, rd, cw);
    applyStimulus(0, IOBASE + 32'h4, 32'h0, 4'h0, t3, cr);
    checkOutput("timer_after_clear", t3, 32'(cr - cw - 2));
    checkOutput("timer_small", {31'b0, (t3 <= 32'd4)}, 32'h1);

    // Three-wait-state instance: abort during WAIT leaves memory untouched.
    applyStimulus(1, 32'h40, 32'h1111_2222, 4'hF, rd, c1);
    applyStimulus(1, 32'h44, 32'h3333_4444, 4'hF, rd, c1);
    applyStimulus(1, IOBASE, 32'hCAFE_F00D, 4'hF, rd, c1);
    applyStimulus(1, 32'h3000_0000, 32'h0, 4'h0, rd, c1);
    @(negedge clk);
    valid[1] = 1'b1;
    addr[1] = 32'h40;
    wdata[1] = 32'hDEAD_BEEF;
    wstrb[1] = 4'hF;
    @(negedge clk);
    valid[1] = 1'b0;
    wstrb[1] = 4'h0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ready[1]) hits++;
    end
    checkOutput("abort_no_ready", 32'(hits), 32'h0);
    applyStimulus(1, 32'h40, 32'h0, 4'h0, rd, c1);
    checkOutput("abort_data_kept", rd, 32'h1111_2222);

    // Reset pulse in the middle of WAIT: no commit, outputs cleared, next request normal.
    @(negedge clk);
    valid[1] = 1'b1;
    addr[1] = 32'h44;
    wdata[1] = 32'h5555_6666;
    wstrb[1] = 4'hF;
    @(posedge clk);
    #1;
    @(negedge clk);
    resetn[1] = 1'b0;
    valid[1] = 1'b0;
    wstrb[1] = 4'h0;
    #1;
    checkOutput("midreset_ready", {31'b0, ready[1]}, 32'h0);
    checkOutput("midreset_gpio", gpio[1], 32'h0);
    checkOutput("midreset_err", {31'b0, err[1]}, 32'h0);
    @(negedge clk);
    resetn[1] = 1'b1;
    gpioModel[1] = 32'h0;
    errModel[1] = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ready[1]) hits++;
    end
    checkOutput("postreset_no_ready", 32'(hits), 32'h0);
    applyStimulus(1, 32'h44, 32'h0, 4'h0, rd, c1);
    checkOutput("postreset_data_kept", rd, 32'h3333_4444);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule

// File: doc/native_mem_slave.md
Name: native_mem_slave

Overview:
- Memory and peripheral responder for the PicoRV32 native memory interface, directly downstream of the CPU top.
- Decodes each `mem_valid` request into one of three regions: on-chip RAM, a small I/O register file, or unmapped space.
- Returns a single-cycle `mem_ready` after a programmable number of wait states.
- Provides a 32-bit GPIO output register, a free-running timer and a sticky bus-error flag.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; must be a power of two, 16..16384.
- WAIT_STATES, 1: extra cycles between request capture and `mem_ready`; range 0..15.
- RAM_BASE, 32'h0000_0000: byte base address of RAM; aligned to 4*MEM_WORDS.
- IO_BASE, 32'h1000_0000: byte base address of the I/O register window (16 bytes).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  request valid from CPU
- mem_instr  in  1  instruction-fetch qualifier; does not affect decode
- mem_ready  out  1  single-cycle completion pulse
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write enables; 0 = read
- mem_rdata  out  32  read data, valid only while mem_ready=1
- gpio_out  out  32  GPIO output register
- bus_err  out  1  sticky error flag: access to unmapped space

Behaviour:
- Reset values (asynchronous, resetn=0):
  - mem_ready=0, mem_rdata=0, gpio_out=0, bus_err=0, timer=0, FSM=IDLE, wait counter=0.
  - RAM contents are not reset.
- Decode uses the address captured at request acceptance:
  - RAM: RAM_BASE <= addr < RAM_BASE+4*MEM_WORDS; word index = addr[log2(MEM_WORDS)+1:2].
  - IO, offset addr[3:2]:
    - 0 = GPIO (RW, byte strobes apply).
    - 1 = TIMER (read returns current count; any write with wstrb!=0 clears it to 0).
    - 2 = STATUS (read {31'b0,bus_err}; write with wdata[0]=1 clears bus_err).
    - 3 = reserved (reads 0, writes ignored, not an error).
  - Otherwise: unmapped.
- FSM states:
  - IDLE: on mem_valid=1, capture addr/wdata/wstrb and region. Go to WAIT if WAIT_STATES>0 (load counter with WAIT_STATES-1), else go to RESP.
  - WAIT: decrement the counter each cycle; at 0 go to RESP. If mem_valid drops, abort to IDLE with no side effects.
  - RESP: assert mem_ready for exactly one cycle; commit the write, or drive mem_rdata. Go to DONE.
  - DONE: one cycle, mem_ready=0, mem_rdata=0; go to IDLE. A new request is accepted only from IDLE.
- Latency: mem_valid sampled high in cycle N gives mem_ready=1 in cycle N+1+WAIT_STATES. Minimum request-to-request spacing is WAIT_STATES+3 cycles.
- Writes commit on the RESP edge only:
  - RAM and GPIO update only the bytes whose mem_wstrb bit is 1.
  - Partial strobes on TIMER still clear the timer.
- Reads:
  - mem_rdata is registered and driven only in the RESP cycle; it is 0 in all other cycles.
  - RAM read returns the word as it was before any write in the same transaction. Reads never write.
- Unmapped access: reads return 32'h0, writes are ignored, bus_err is set in the RESP cycle. Set takes priority over a simultaneous STATUS clear (impossible, single port, but stated).
- Timer:
  - Increments every cycle and wraps 32'hFFFF_FFFF to 0.
  - A write-clear in the RESP cycle makes it 0 on the next cycle.
  - A read returns the value registered in the RESP cycle.
- Reset mid-transaction: the FSM returns to IDLE, no write is committed, and mem_ready stays 0 until a fresh request.
- mem_instr is ignored for decode and permissions.

Test Plan:
- Reset, WAIT_STATES=1:
  - Stimulus: write RAM addr 0x10 data 0xA5A5_1234 wstrb 4'hF, then read 0x10.
  - Required: mem_ready 2 cycles after valid; read returns 0xA5A5_1234.
- Byte strobes:
  - Stimulus: write 0xFFFF_FFFF to 0x20, then write 0x0000_00AB with wstrb 4'b0001, then read.
  - Required: read returns 0xFFFF_FFAB.
- GPIO:
  - Stimulus: write IO_BASE+0 data 0x1234_5678 wstrb 4'b1100.
  - Required: gpio_out=0x1234_0000 the cycle after mem_ready; readback matches.
- Timer:
  - Stimulus: read IO_BASE+4 twice with 10 idle cycles between; write IO_BASE+4; read again.
  - Required: difference between the first two reads = 10 + transaction length; the post-clear read is small (<= WAIT_STATES+3).
- Error:
  - Stimulus: read 0x2000_0000.
  - Required: rdata 0, bus_err=1 and stays 1.
  - Then write STATUS wdata 1: bus_err=0.
- Abort and reset:
  - Stimulus: WAIT_STATES=3, write RAM 0x40; deassert mem_valid after 1 cycle; read 0x40. Separately, pulse resetn mid-WAIT.
  - Required: no mem_ready during abort; old data preserved; after reset, mem_ready=0 and FSM accepts the next request normally.
